// File: rtl/dataout_uart_tx.sv
// rtl/dataout_uart_tx.sv - streams each new CPU debug byte off-chip as a UART frame
// Define DATAOUT_TX_PARITY_EN to add an even-parity bit (8E1); default framing is 8N1.
module dataout_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [7:0]                       data_out_i,
  output logic                             tx_o,
  output logic                             busy_o,
  output logic                             overflow_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_d;
  logic          tx_q, busy_q;
`ifdef DATAOUT_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [7:0]    last_q;
  logic          overflow_q;
  logic          push, pop, full, empty, accept;

  assign full   = (count_q == CW'(FIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign push   = (data_out_i != last_q);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign accept = push && (!full || pop);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    tx_d      = 1'b1;
`ifdef DATAOUT_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (timer_q == TIMER_LAST) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef DATAOUT_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef DATAOUT_TX_PARITY_EN
      S_PARITY: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
`ifdef DATAOUT_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
    end

    // Line level is derived from the next state so tx_o is registered with no extra lag.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef DATAOUT_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
`ifdef DATAOUT_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= (state_d != S_IDLE);
`ifdef DATAOUT_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
      if (push)
        last_q <= data_out_i;
      if (push && full && !pop)
        overflow_q <= 1'b1;
      if (accept)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(accept) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && accept)
      mem_q[wr_ptr_q] <= data_out_i;
  end

  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_dataout_uart_tx.sv
// tb/tb_dataout_uart_tx.sv - self-checking bench for dataout_uart_tx
module tb_dataout_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef DATAOUT_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [NB-1:0] A5_FRAME = {1'b1, 1'b0, 8'hA5, 1'b0};
`else
  localparam int NB = 10;
  localparam logic [NB-1:0] A5_FRAME = {1'b1, 8'hA5, 1'b0};
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data_out = 8'h00;
  logic          tx, busy, ovf;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  dataout_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .data_out_i(data_out),
    .tx_o(tx),
    .busy_o(busy),
    .overflow_o(ovf),
    .fifo_count_o(cnt)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a byte queue plus the frame currently on the line as a bit list.
  logic [7:0]    q[$];
  logic [7:0]    m_last = 8'h00;
  bit            m_ovf = 1'b0;
  bit            m_active = 1'b0;
  int            m_pos = 0;
  logic [NB-1:0] m_bits = '1;

  function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
`ifdef DATAOUT_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b1, b, 1'b0};
`endif
  endfunction

  task automatic model_edge(input logic [7:0] d, input logic r);
    if (r) begin
      q.delete();
      m_last = 8'h00; m_ovf = 1'b0; m_active = 1'b0; m_pos = 0;
      return;
    end
    if (m_active && m_pos < NB * CPB - 1) begin
      m_pos++;
    end else begin
      m_active = 1'b0;
      if (q.size() > 0) begin
        m_bits   = frame_of(q.pop_front());
        m_active = 1'b1;
        m_pos    = 0;
      end
    end
    if (d != m_last) begin
      m_last = d;
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [7:0] d, input logic r);
    logic [NB-1:0] sh;
    logic          exp_tx;
    data_out = d;
    rst      = r;
    @(posedge clk);
    model_edge(d, r);
    #1;
    sh     = m_bits >> (m_pos / CPB);
    exp_tx = m_active ? sh[0] : 1'b1;
    check("model", 32'({tx, busy, ovf, cnt}), 32'({exp_tx, m_active, m_ovf, CW'(q.size())}));
  endtask

  task automatic frame_check(input logic [7:0] b, input logic [NB-1:0] f, input string name);
    int            bad = 0;
    int            busy_n = 0;
    logic [NB-1:0] sh;
    for (int i = 0; i < NB * CPB; i++) begin
      cycle(b, 1'b0);
      sh = f >> (i / CPB);
      if (tx !== sh[0]) bad++;
      if (busy === 1'b1) busy_n++;
    end
    check({name, "_bits"}, 32'(bad), 32'(0));
    check({name, "_busy"}, 32'(busy_n), 32'(NB * CPB));
    cycle(b, 1'b0);
    check({name, "_end"}, 32'({tx, busy}), 32'(2'b10));
  endtask

  typedef struct {
    logic          rst;
    logic [7:0]    d;
    logic          tx;
    logic          busy;
    logic          ovf;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vt[12];

  initial begin
    int            busy_n, rises, lows, rate;
    logic          prev_busy;
    logic [7:0]    cur;

    // Burst of six distinct bytes: first pops at once, four queue, sixth is dropped.
    vt[0]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[2]  = '{1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 3'd1};
    vt[3]  = '{1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 3'd1};
    vt[4]  = '{1'b0, 8'h03, 1'b0, 1'b1, 1'b0, 3'd2};
    vt[5]  = '{1'b0, 8'h04, 1'b0, 1'b1, 1'b0, 3'd3};
    vt[6]  = '{1'b0, 8'h05, 1'b0, 1'b1, 1'b0, 3'd4};
    vt[7]  = '{1'b0, 8'h06, 1'b1, 1'b1, 1'b1, 3'd4};
    vt[8]  = '{1'b0, 8'h06, 1'b1, 1'b1, 1'b1, 3'd4};
    vt[9]  = '{1'b0, 8'h06, 1'b1, 1'b1, 1'b1, 3'd4};
    vt[10] = '{1'b0, 8'h06, 1'b1, 1'b1, 1'b1, 3'd4};
    vt[11] = '{1'b0, 8'h06, 1'b0, 1'b1, 1'b1, 3'd4};

    // Reset then idle on 0x00 for 50 cycles.
    cycle(8'h00, 1'b1);
    check("reset_state", 32'({tx, busy, ovf, cnt}), 32'({1'b1, 1'b0, 1'b0, 3'd0}));
    for (int i = 0; i < 50; i++) begin
      cycle(8'h00, 1'b0);
      check("idle_hold", 32'({tx, busy, ovf, cnt}), 32'({1'b1, 1'b0, 1'b0, 3'd0}));
    end

    // Single 0xA5 frame, then the value is held with no further frames.
    cycle(8'hA5, 1'b0);
    check("a5_push", 32'({tx, busy, cnt}), 32'({1'b1, 1'b0, 3'd1}));
    frame_check(8'hA5, A5_FRAME, "a5");
    lows = 0; busy_n = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(8'hA5, 1'b0);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busy_n++;
    end
    check("a5_hold_tx", 32'(lows), 32'(0));
    check("a5_hold_busy", 32'(busy_n), 32'(0));

    for (int i = 0; i < 12; i++) begin
      cycle(vt[i].d, vt[i].rst);
      check($sformatf("vec%0d", i), 32'({tx, busy, ovf, cnt}),
            32'({vt[i].tx, vt[i].busy, vt[i].ovf, vt[i].cnt}));
    end

    // Remaining frames 0x01..0x05 must run back-to-back with no idle gap.
    busy_n = 0; rises = 0; prev_busy = 1'b1;
    for (int i = 0; i < 220; i++) begin
      cycle(8'h06, 1'b0);
      if (busy === 1'b1) busy_n++;
      if (busy === 1'b1 && prev_busy === 1'b0) rises++;
      prev_busy = busy;
    end
    check("burst_busy", 32'(busy_n), 32'(5 * NB * CPB - 9));
    check("burst_gap", 32'(rises), 32'(0));
    check("burst_end", 32'({ovf, cnt}), 32'({1'b1, 3'd0}));

    // Reset in the middle of the data bits of a frame.
    cycle(8'hA5, 1'b0);
    for (int i = 0; i < 11; i++) cycle(8'hA5, 1'b0);
    check("pre_rst", 32'({busy, ovf}), 32'(2'b11));
    cycle(8'hA5, 1'b1);
    check("mid_rst", 32'({tx, busy, ovf, cnt}), 32'({1'b1, 1'b0, 1'b0, 3'd0}));
    cycle(8'hA5, 1'b0);
    check("rst_repush", 32'({tx, busy, cnt}), 32'({1'b1, 1'b0, 3'd1}));
    frame_check(8'hA5, A5_FRAME, "rst_a5");

`ifdef DATAOUT_TX_PARITY_EN
    cycle(8'h00, 1'b1);
    cycle(8'h00, 1'b0);
    cycle(8'h07, 1'b0);
    frame_check(8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, "par07");
`endif

    // Random traffic alternating heavy bursts and sparse changes, with rare resets.
    cur = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      rate = ((i % 1000) < 500) ? 30 : 2;
      if ($urandom_range(0, 99) < rate) cur = 8'($urandom);
      cycle(cur, ($urandom_range(0, 599) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
